// File: rtl/kgp_pkg.sv
// Shared KGP-RISC definitions: branch opcodes, flag layout and link register index.
package kgp_pkg;

    localparam int unsigned BR_OP_W = 4;
    localparam int unsigned FLAG_W  = 4;

    typedef enum logic [BR_OP_W-1:0] {
        BR_NONE = 4'b0000,
        BR_B    = 4'b0001,
        BR_BR   = 4'b0010,
        BR_BLTZ = 4'b0011,
        BR_BZ   = 4'b0100,
        BR_BNZ  = 4'b0101,
        BR_BL   = 4'b0110,
        BR_BCY  = 4'b0111,
        BR_BNCY = 4'b1000
    } br_op_t;

    localparam int unsigned FLAG_C = 0;
    localparam int unsigned FLAG_Z = 1;
    localparam int unsigned FLAG_S = 2;
    localparam int unsigned FLAG_V = 3;

    localparam logic [4:0] LINK_REG = 5'd31;

    // Architectural flag register layout, carry in bit 0.
    typedef struct packed {
        logic v;
        logic s;
        logic z;
        logic c;
    } flags_t;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch-condition evaluator; reserved opcodes resolve as NONE.
module branch_cond
    import kgp_pkg::*;
#(
    parameter int unsigned PC_W = 32
) (
    input  logic [BR_OP_W-1:0] br_op,
    input  logic [PC_W-1:0]    rs_val,
    input  logic [FLAG_W-1:0]  flags_q,
    output logic               taken,
    output logic               is_reg_target,
    output logic               is_link
);

    logic rs_zero;
    logic unused_flags;

    assign rs_zero      = (rs_val == '0);
    assign unused_flags = ^{flags_q[FLAG_V], flags_q[FLAG_S], flags_q[FLAG_Z]};

    always_comb begin
        taken         = 1'b0;
        is_reg_target = 1'b0;
        is_link       = 1'b0;
        case (br_op_t'(br_op))
            BR_B:    taken = 1'b1;
            BR_BR: begin
                taken         = 1'b1;
                is_reg_target = 1'b1;
            end
            BR_BLTZ: taken = rs_val[PC_W-1];
            BR_BZ:   taken = rs_zero;
            BR_BNZ:  taken = !rs_zero;
            BR_BL: begin
                taken   = 1'b1;
                is_link = 1'b1;
            end
            // Conditional-on-carry uses the registered flags, never the live ALU outputs.
            BR_BCY:  taken = flags_q[FLAG_C];
            BR_BNCY: taken = !flags_q[FLAG_C];
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_branch_unit.sv
// PC register, flag register and branch target generation for the KGP-RISC datapath.
module pc_branch_unit
    import kgp_pkg::*;
#(
    parameter int unsigned     PC_W     = 32,
    parameter int unsigned     OFF_W    = 26,
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic [BR_OP_W-1:0] br_op,
    input  logic [OFF_W-1:0]   br_off,
    input  logic [PC_W-1:0]    rs_val,
    input  logic               flag_we,
    input  logic               carryFlag,
    input  logic               zFlag,
    input  logic               signFlag,
    input  logic               overflowFlag,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pc_plus4,
    output logic               taken,
    output logic               link_we,
    output logic [PC_W-1:0]    link_data,
    output logic [FLAG_W-1:0]  flags_q,
    output logic               misalign
);

    localparam int unsigned EXT_W = PC_W - OFF_W;

    logic            is_reg_target;
    logic            is_link;
    logic [PC_W-1:0] off_words;
    logic [PC_W-1:0] off_bytes;
    logic [PC_W-1:0] rel_target;
    logic [PC_W-1:0] reg_target;
    logic [PC_W-1:0] next_pc;
    flags_t          alu_flags;

    branch_cond #(
        .PC_W (PC_W)
    ) u_branch_cond (
        .br_op         (br_op),
        .rs_val        (rs_val),
        .flags_q       (flags_q),
        .taken         (taken),
        .is_reg_target (is_reg_target),
        .is_link       (is_link)
    );

    // Target arithmetic wraps modulo 2^PC_W.
    assign pc_plus4   = pc + PC_W'(4);
    assign off_words  = {{EXT_W{br_off[OFF_W-1]}}, br_off};
    assign off_bytes  = {off_words[PC_W-3:0], 2'b00};
    assign rel_target = pc_plus4 + off_bytes;
    assign reg_target = {rs_val[PC_W-1:2], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (taken) begin
            next_pc = is_reg_target ? reg_target : rel_target;
        end
    end

    assign misalign  = is_reg_target && (rs_val[1:0] != 2'b00);
    assign link_we   = is_link && !stall;
    assign link_data = pc_plus4;

    assign alu_flags.v = overflowFlag;
    assign alu_flags.s = signFlag;
    assign alu_flags.z = zFlag;
    assign alu_flags.c = carryFlag;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (!stall) begin
            pc <= next_pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q <= '0;
        end else if (flag_we && !stall) begin
            flags_q <= alu_flags;
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboarded bench for pc_branch_unit: directed plan followed by randomized instruction stream.
module tb_pc_branch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [3:0]  br_op;
    logic [25:0] br_off;
    logic [31:0] rs_val;
    logic        flag_we;
    logic        carryFlag, zFlag, signFlag, overflowFlag;
    logic [31:0] pc, pc_plus4, link_data;
    logic        taken, link_we, misalign;
    logic [3:0]  flags_q;

    pc_branch_unit #(
        .PC_W     (32),
        .OFF_W    (26),
        .RESET_PC (RST_PC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .br_op        (br_op),
        .br_off       (br_off),
        .rs_val       (rs_val),
        .flag_we      (flag_we),
        .carryFlag    (carryFlag),
        .zFlag        (zFlag),
        .signFlag     (signFlag),
        .overflowFlag (overflowFlag),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .taken        (taken),
        .link_we      (link_we),
        .link_data    (link_data),
        .flags_q      (flags_q),
        .misalign     (misalign)
    );

    typedef struct {
        logic [31:0] pc;
        logic [3:0]  flags;
        logic [31:0] pc4;
        logic        tk;
        logic        mis;
        logic        lwe;
        logic [31:0] ld;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_pc    = RST_PC;
    logic [3:0]  m_flags = 4'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: opcode semantics written straight from the ISA rules.
    task automatic step(input int op, input int off, input logic [31:0] rs,
                        input logic fwe, input logic [3:0] vszc, input logic stl,
                        input logic rlow, input logic mid_rst);
        exp_t        e;
        logic        tk;
        logic [31:0] tgt;
        @(posedge clk);
        #2;
        br_op        = 4'(op);
        br_off       = 26'(off);
        rs_val       = rs;
        flag_we      = fwe;
        {overflowFlag, signFlag, zFlag, carryFlag} = vszc;
        stall        = stl;
        rst          = !rlow;
        if (mid_rst) begin
            #1;
            rst = 1'b0;
        end
        if (!rst) begin
            m_pc    = RST_PC;
            m_flags = 4'h0;
        end
        case (op)
            1, 6:    tk = 1'b1;
            2:       tk = 1'b1;
            3:       tk = rs[31];
            4:       tk = (rs == 32'd0);
            5:       tk = (rs != 32'd0);
            7:       tk = m_flags[0];
            8:       tk = !m_flags[0];
            default: tk = 1'b0;
        endcase
        if (op == 2) tgt = rs & 32'hFFFF_FFFC;
        else         tgt = 32'(m_pc + 32'd4 + 32'(off * 4));
        e.pc    = m_pc;
        e.flags = m_flags;
        e.pc4   = 32'(m_pc + 32'd4);
        e.tk    = tk;
        e.mis   = (op == 2) && (rs[1:0] != 2'b00);
        e.lwe   = (op == 6) && !stl;
        e.ld    = e.pc4;
        sb_q.push_back(e);
        if (rst && !stl) begin
            m_pc = tk ? tgt : e.pc4;
            if (fwe) m_flags = vszc;
        end
    endtask

    task automatic op_only(input int op, input int off, input logic [31:0] rs);
        step(op, off, rs, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: every negedge the DUT presents a resolved cycle; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("pc",        pc,                 e.pc);
                chk("flags_q",   32'(flags_q),       32'(e.flags));
                chk("pc_plus4",  pc_plus4,           e.pc4);
                chk("taken",     32'(taken),         32'(e.tk));
                chk("misalign",  32'(misalign),      32'(e.mis));
                chk("link_we",   32'(link_we),       32'(e.lwe));
                chk("link_data", link_data,          e.ld);
            end
        end
    end

    initial begin
        int          op, off;
        logic [31:0] rs;
        rst = 1'b0; stall = 1'b0; br_op = 4'h0; br_off = '0; rs_val = '0;
        flag_we = 1'b0; carryFlag = 1'b0; zFlag = 1'b0; signFlag = 1'b0; overflowFlag = 1'b0;

        // Reset held, then released; NONE steps the PC.
        step(0, 0, 32'd0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        step(0, 0, 32'd0, 1'b1, 4'hF, 1'b0, 1'b1, 1'b0);
        op_only(0, 0, 32'd0);
        op_only(0, 0, 32'd0);
        op_only(0, 0, 32'd0);
        op_only(0, 0, 32'd0);
        // pc=16: B -2 -> 12, then BL +3 -> 28 with link 16.
        op_only(1, -2, 32'd0);
        op_only(6, 3, 32'd0);
        op_only(2, 0, 32'h0000_0103);
        op_only(4, 5, 32'd0);
        op_only(5, 5, 32'd0);
        op_only(3, -1, 32'h8000_0000);
        // Carry set, then BCY sees it.
        step(0, 0, 32'd0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        op_only(7, 2, 32'd0);
        // Clear carry, then BCY coinciding with a carry-setting update resolves on the old flags.
        step(0, 0, 32'd0, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
        step(7, 2, 32'd0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        op_only(8, 2, 32'd0);
        // Stalled BL with a flag write holds everything.
        step(6, 7, 32'd0, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b0);
        op_only(0, 0, 32'd0);
        // Wrap-around at the top of the address space.
        op_only(2, 0, 32'hFFFF_FFFC);
        op_only(0, 0, 32'd0);
        op_only(0, 0, 32'd0);
        // Asynchronous reset during a taken branch, then release.
        step(1, 100, 32'd0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1);
        op_only(0, 0, 32'd0);
        op_only(0, 0, 32'd0);

        for (int i = 0; i < 400; i++) begin
            op  = int'($urandom_range(0, 15));
            off = int'($signed(26'($urandom)));
            if ($urandom_range(0, 3) == 0) off = int'($urandom_range(0, 8)) - 4;
            rs  = $urandom;
            if ($urandom_range(0, 3) == 0) rs = 32'd0;
            step(op, off, rs, ($urandom_range(0, 2) == 0), 4'($urandom),
                 ($urandom_range(0, 7) == 0), 1'b0, ($urandom_range(0, 63) == 0));
        end

        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
